// File: rtl/imem_axil_loader_if.sv
// AXI4-Lite bus between the program loader (master) and the instruction memory (slave).
interface imem_axil_loader_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/imem_axil_loader.sv
// Packs byte-serial program data into 32-bit words, writes each over AXI4-Lite,
// and performs single-word read-back on request.
module imem_axil_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       byte_valid,
  input  logic [7:0]                 instr_i,
  input  logic [4:0]                 address,
  output logic                       byte_ready,
  input  logic                       rd_req,
  output logic [31:0]                rd_data,
  output logic                       rd_done,
  output logic                       busy,
  output logic                       err,
  imem_axil_loader_if.master         m_axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t      state, state_next;
  logic        ready_en;
  logic [1:0]  byte_cnt;
  logic [23:0] word_lo;
  logic        aw_pend, w_pend;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic [31:0] word_addr;
  logic        byte_acc, last_byte, rd_start;

  assign word_addr  = BASE_ADDR + {25'd0, address, 2'b00};
  // ready_en keeps byte_ready low until the first edge after reset release
  assign byte_ready = ready_en && (state == IDLE);
  assign byte_acc   = byte_valid && byte_ready;
  assign last_byte  = byte_acc && (byte_cnt == 2'd3);
  assign rd_start   = ready_en && (state == IDLE) && rd_req && (byte_cnt == 2'd0) && !byte_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (last_byte)     state_next = WR;
        else if (rd_start) state_next = RD_ADDR;
      end
      WR: begin
        if ((!aw_pend || m_axi.awready) && (!w_pend || m_axi.wready)) state_next = WR_RESP;
      end
      WR_RESP: if (m_axi.bvalid)  state_next = IDLE;
      RD_ADDR: if (m_axi.arready) state_next = RD_DATA;
      RD_DATA: if (m_axi.rvalid)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      byte_cnt <= '0;
      word_lo  <= '0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      araddr_q <= '0;
      rd_data  <= '0;
      rd_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rd_done  <= 1'b0;
      if (byte_acc) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_lo[7:0]   <= instr_i;
          2'd1: word_lo[15:8]  <= instr_i;
          2'd2: word_lo[23:16] <= instr_i;
          2'd3: begin
            wdata_q  <= {instr_i, word_lo};
            awaddr_q <= word_addr;
            aw_pend  <= 1'b1;
            w_pend   <= 1'b1;
          end
        endcase
      end
      if (rd_start) araddr_q <= word_addr;
      // each valid retires on its own handshake and stays low for the rest of the write
      if (state == WR) begin
        if (m_axi.awready) aw_pend <= 1'b0;
        if (m_axi.wready)  w_pend  <= 1'b0;
      end
      if ((state == WR_RESP) && m_axi.bvalid && (m_axi.bresp != 2'b00)) err <= 1'b1;
      if ((state == RD_DATA) && m_axi.rvalid) begin
        rd_data <= m_axi.rdata;
        rd_done <= 1'b1;
        if (m_axi.rresp != 2'b00) err <= 1'b1;
      end
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = aw_pend;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = w_pend;
  assign m_axi.bready  = (state == WR_RESP);
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = (state == RD_ADDR);
  assign m_axi.rready  = (state == RD_DATA);
  assign busy          = (state != IDLE);

endmodule
